// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial receive path (and the future transmitter):
//   parity mode codes, the receiver FSM state encoding, the default baud
//   divisor, and the 3-sample majority helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    // Parity mode codes used for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 5 MHz / 9600 baud, rounded to the nearest integer divisor.
    localparam int BAUD_9600_AT_5MHZ = 521;

    // Receiver FSM states. ST_ prefix keeps the names clear of the PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Majority of three samples: 1 when at least two samples are 1.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
//   Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, restarting at 0 on
//   i_restart. Emits one-cycle strobes while the count equals MID-1, MID, MID+1
//   and CLKS_PER_BIT-1 (MID = CLKS_PER_BIT/2). The strobes are registered from
//   the next-count value, so each strobe is aligned with its count value.
// Ports
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset (count 0, strobes low)
//   i_restart  in  force count to 0 on the next edge
//   o_mid_m1   out count == MID-1
//   o_mid      out count == MID
//   o_mid_p1   out count == MID+1
//   o_bit_end  out count == CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_mid_m1,
    output logic o_mid,
    output logic o_mid_p1,
    output logic o_bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] C_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MID_M1 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] C_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] C_MID_P1 = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_mid_m1;
    logic             r_mid;
    logic             r_mid_p1;
    logic             r_bit_end;

    // Next count: restart wins, otherwise increment and wrap at the bit end.
    always_comb begin
        w_cnt_next = C_ZERO;
        if (i_restart) begin
            w_cnt_next = C_ZERO;
        end else if (r_cnt == C_LAST) begin
            w_cnt_next = C_ZERO;
        end else begin
            w_cnt_next = r_cnt + C_ONE;
        end
    end

    // Counter and strobes decoded from the value the counter is about to take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= C_ZERO;
            r_mid_m1  <= 1'b0;
            r_mid     <= 1'b0;
            r_mid_p1  <= 1'b0;
            r_bit_end <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_mid_m1  <= (w_cnt_next == C_MID_M1);
            r_mid     <= (w_cnt_next == C_MID);
            r_mid_p1  <= (w_cnt_next == C_MID_P1);
            r_bit_end <= (w_cnt_next == C_LAST);
        end
    end

    assign o_mid_m1  = r_mid_m1;
    assign o_mid     = r_mid;
    assign o_mid_p1  = r_mid_p1;
    assign o_bit_end = r_bit_end;

endmodule

// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//   UART-style receiver: synchronises rxd, validates the start bit, majority-
//   votes three mid-bit samples per bit, checks optional parity and 1/2 stop
//   bits, and presents each word plus error flags through a single-entry
//   valid/ready holding buffer.
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   rxd         in   asynchronous serial line, idle high
//   rx_data     out  received word (valid while rx_valid)
//   rx_valid    out  word present in holding buffer
//   rx_ready    in   consumer accepts when rx_valid && rx_ready
//   frame_err   out  a stop bit was sampled 0 (qualified by rx_valid)
//   parity_err  out  parity mismatch (qualified by rx_valid)
//   overrun     out  1-cycle pulse: frame completed with buffer full, word dropped
//   busy        out  receiver FSM not idle
// -----------------------------------------------------------------------------
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_9600_AT_5MHZ,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [BC_W-1:0] C_BC_ZERO = BC_W'(0);
    localparam logic [BC_W-1:0] C_BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0] C_BC_LAST = BC_W'(DATA_BITS);
    localparam logic            C_STOP_LAST = 1'(STOP_BITS - 1);

    // Synchroniser and edge-detect flops
    logic r_sync1;
    logic r_rxd_s;
    logic r_rxd_d;

    // FSM state and frame assembly
    rx_state_t            r_state;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic [BC_W-1:0]      r_bitcnt;
    logic                 r_stopcnt;
    logic                 r_fe_acc;
    logic                 r_pe_acc;
    logic                 r_busy;

    // Holding buffer
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    // Timer strobes and decoded conditions
    logic w_mid_m1;
    logic w_mid;
    logic w_mid_p1;
    logic w_bit_end;
    logic w_maj;
    logic w_start_edge;
    logic w_complete;
    logic w_par_xor;
    logic w_par_bad;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_start_edge),
        .o_mid_m1  (w_mid_m1),
        .o_mid     (w_mid),
        .o_mid_p1  (w_mid_p1),
        .o_bit_end (w_bit_end)
    );

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
            r_rxd_d <= r_rxd_s;
        end
    end

    // The third sample is the live synchronised line at MID+1, so the vote is
    // valid exactly when w_mid_p1 is high.
    assign w_maj        = majority3(r_samp_a, r_samp_b, r_rxd_s);
    assign w_start_edge = (r_state == ST_IDLE) && r_rxd_d && !r_rxd_s;
    assign w_complete   = (r_state == ST_STOP) && w_mid_p1 && (r_stopcnt == C_STOP_LAST);

    // Parity check of the assembled data plus the voted parity bit.
    always_comb begin
        w_par_xor = (^r_shift) ^ w_maj;
        if (PARITY == PAR_ODD) begin
            w_par_bad = ~w_par_xor;
        end else if (PARITY == PAR_EVEN) begin
            w_par_bad = w_par_xor;
        end else begin
            w_par_bad = 1'b0;
        end
    end

    // Receiver FSM: sampling, start validation, data shift, parity and stop checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_samp_a  <= 1'b1;
            r_samp_b  <= 1'b1;
            r_shift   <= '0;
            r_bitcnt  <= C_BC_ZERO;
            r_stopcnt <= 1'b0;
            r_fe_acc  <= 1'b0;
            r_pe_acc  <= 1'b0;
        end else begin
            if (w_mid_m1) begin
                r_samp_a <= r_rxd_s;
            end
            if (w_mid) begin
                r_samp_b <= r_rxd_s;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                        r_bitcnt  <= C_BC_ZERO;
                        r_stopcnt <= 1'b0;
                        r_fe_acc  <= 1'b0;
                        r_pe_acc  <= 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was a glitch: drop silently.
                    if (w_mid_p1 && w_maj) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_mid_p1) begin
                        r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + C_BC_ONE;
                    end
                    if (w_bit_end && (r_bitcnt == C_BC_LAST)) begin
                        r_bitcnt <= C_BC_ZERO;
                        if (PARITY != PAR_NONE) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_mid_p1) begin
                        r_pe_acc <= w_par_bad;
                    end
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Last stop bit finishes at its vote, half a bit early, so a
                    // back-to-back start edge is seen from IDLE.
                    if (w_mid_p1) begin
                        if (!w_maj) begin
                            r_fe_acc <= 1'b1;
                        end
                        if (r_stopcnt == C_STOP_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stopcnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry holding buffer with overrun detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_rx_valid   <= 1'b1;
                    r_frame_err  <= r_fe_acc | ~w_maj;
                    r_parity_err <= r_pe_acc;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
//   Two receivers at 16 clocks/bit: dut_a is 8N1, dut_b is 8E1. Frames are
//   driven bit by bit on separate lines; a negedge monitor records every
//   accepted word and counts overrun pulses. Expected words and flags come
//   from the frame contents chosen by the bench.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;
    import serial_pkg::*;

    localparam int CPB = 16;
    localparam int MID = CPB / 2;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_a, rxd_b;
    logic       rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       fe_a, fe_b, pe_a, pe_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;

    cap_t qa[$];
    cap_t qb[$];
    int   ovf_a = 0;
    int   checks = 0;
    int   errors = 0;

    serial_frame_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a));

    serial_frame_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Record each handshake and each overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_a && rdy_a) qa.push_back(cap_t'({data_a, fe_a, pe_a}));
        if (valid_b && rdy_b) qb.push_back(cap_t'({data_b, fe_b, pe_b}));
        if (ovr_a) ovf_a++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    // One bit period; optional one-clock inversion at mid-bit.
    task automatic send_bit(input bit sel, input logic v, input bit glitch);
        drive(sel, v);
        if (glitch) begin
            repeat (MID) tick();
            drive(sel, ~v);
            tick();
            drive(sel, v);
            repeat (CPB - MID - 1) tick();
        end else begin
            repeat (CPB) tick();
        end
    endtask

    task automatic idle_bits(input bit sel, input int n);
        for (int i = 0; i < n; i++) send_bit(sel, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] w, input bit use_par,
                              input logic pbit, input logic stop_v, input int glitch_bit);
        send_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, w[i], (i == glitch_bit));
        if (use_par) send_bit(sel, pbit, 1'b0);
        send_bit(sel, stop_v, 1'b0);
        if (!stop_v) send_bit(sel, 1'b1, 1'b0);
    endtask

    // Even parity rule: data ones plus the parity bit must total an even count.
    function automatic logic even_par_err(input logic [7:0] w, input logic pbit);
        return ((($countones(w) + int'(pbit)) % 2) != 0);
    endfunction

    task automatic expect_word(input bit sel, input string tag, input logic [7:0] d,
                               input logic fe, input logic pe);
        cap_t c;
        int   n = 0;
        int   sz;
        sz = sel ? qb.size() : qa.size();
        while (sz == 0 && n < 20 * CPB) begin
            tick();
            n++;
            sz = sel ? qb.size() : qa.size();
        end
        check({tag, "_arrived"}, 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            c = sel ? qb.pop_front() : qa.pop_front();
            check({tag, "_data"}, 32'(c.d), 32'(d));
            check({tag, "_frame_err"}, 32'(c.fe), 32'(fe));
            check({tag, "_parity_err"}, 32'(c.pe), 32'(pe));
        end
    endtask

    initial begin
        logic [7:0] w;
        logic       stop_v;
        logic       bad;
        logic       pbit;
        int         ovf0;
        int         n;

        rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) tick();
        check("reset_valid", 32'(valid_a), 32'd0);
        check("reset_data", 32'(data_a), 32'd0);
        check("reset_flags", 32'({fe_a, pe_a, ovr_a}), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        idle_bits(1'b0, 2);

        // 8N1 0xA5, delivered once
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        expect_word(1'b0, "8n1_a5", 8'hA5, 1'b0, 1'b0);
        idle_bits(1'b0, 1);
        check("8n1_a5_once", 32'(qa.size()), 32'd0);

        // 8E1 0x37 with wrong parity bit 0, then with correct bit 1
        send_frame(1'b1, 8'h37, 1'b1, 1'b0, 1'b1, -1);
        expect_word(1'b1, "8e1_bad", 8'h37, 1'b0, 1'b1);
        send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1, -1);
        expect_word(1'b1, "8e1_good", 8'h37, 1'b0, 1'b0);

        // False start: 4 clocks low
        drive(1'b0, 1'b0);
        repeat (4) tick();
        check("false_start_busy", 32'(busy_a), 32'd1);
        drive(1'b0, 1'b1);
        n = 0;
        while (busy_a && n < 9) begin tick(); n++; end
        check("false_start_idle", 32'(busy_a), 32'd0);
        idle_bits(1'b0, 2);
        check("false_start_no_word", 32'(qa.size()), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        expect_word(1'b0, "rearm", 8'h3C, 1'b0, 1'b0);

        // Overrun: two frames back-to-back with consumer stalled
        rdy_a = 1'b0;
        ovf0 = ovf_a;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(1'b0, 1);
        check("ovr_valid", 32'(valid_a), 32'd1);
        check("ovr_hold_data", 32'(data_a), 32'h11);
        check("ovr_pulses", 32'(ovf_a - ovf0), 32'd1);
        rdy_a = 1'b1;
        tick();
        check("ovr_drained", 32'(valid_a), 32'd0);
        expect_word(1'b0, "ovr_accept", 8'h11, 1'b0, 1'b0);

        // Glitch on data bit 3 of 0xFF
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
        expect_word(1'b0, "glitch", 8'hFF, 1'b0, 1'b0);

        // Random 8N1 words, occasional bad stop bit, random idle gaps
        for (int k = 0; k < 8; k++) begin
            w = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(1'b0, w, 1'b0, 1'b0, stop_v, -1);
            expect_word(1'b0, "rand_8n1", w, ~stop_v, 1'b0);
            idle_bits(1'b0, $urandom_range(0, 2));
        end

        // Random 8E1 words, parity bit randomly right or wrong
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            bad = 1'($urandom_range(0, 1));
            pbit = 1'($countones(w) % 2) ^ bad;
            send_frame(1'b1, w, 1'b1, pbit, 1'b1, -1);
            expect_word(1'b1, "rand_8e1", w, 1'b0, even_par_err(w, pbit));
        end

        // Break: 40 bit times low yields exactly one 0x00 with frame error
        drive(1'b0, 1'b0);
        repeat (40 * CPB) tick();
        drive(1'b0, 1'b1);
        repeat (2 * CPB) tick();
        expect_word(1'b0, "break", 8'h00, 1'b1, 1'b0);
        check("break_once", 32'(qa.size()), 32'd0);

        // Reset in the middle of 0x5A
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, w[i] ^ w[i] ^ ((8'h5A >> i) & 8'h01) != 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        check("midreset_outputs", 32'({data_a, valid_a, fe_a, pe_a, ovr_a, busy_a}), 32'd0);
        drive(1'b0, 1'b1);
        tick();
        rst = 1'b0;
        repeat (2 * CPB) tick();
        check("midreset_no_word", 32'(qa.size()), 32'd0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
        expect_word(1'b0, "after_reset", 8'h5A, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
